// File: rtl/sum_to_bcd.sv
// Iterative double-dabble converter: turns the {cout, sum} adder result into
// packed BCD digits, with valid/ready handshakes on both sides.
module sum_to_bcd #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_cout,
    input  logic [WIDTH-1:0]      in_sum,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_digits
);

    localparam int VW = WIDTH + 1;
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(VW + 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam longint unsigned MAX_VALUE = (64'd1 << VW) - 64'd1;

    generate
        if (pow10(DIGITS) <= MAX_VALUE) begin : g_bad_digits
            $fatal(1, "sum_to_bcd: DIGITS too small to represent a WIDTH+1 bit value");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [VW-1:0]   bin_q;
    logic [BW-1:0]   scratch_q;
    logic [CW-1:0]   cnt_q;
    logic [BW-1:0]   bcd_q;
    logic            out_valid_q;

    logic [BW-1:0]   scratch_adj;
    logic [BW-1:0]   scratch_d;
    logic [VW-1:0]   bin_d;
    logic            load;

    // Each digit >= 5 gets +3 so the following left shift carries into the next digit.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign scratch_adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5)
                                          ? scratch_q[gi*4 +: 4] + 4'd3
                                          : scratch_q[gi*4 +: 4];
        end
    endgenerate

    assign scratch_d = {scratch_adj[BW-2:0], bin_q[VW-1]};
    assign bin_d     = {bin_q[VW-2:0], 1'b0};

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign load       = in_valid && in_ready;
    assign out_valid  = out_valid_q;
    assign bcd_digits = bcd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            scratch_q   <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        bin_q     <= {in_cout, in_sum};
                        scratch_q <= '0;
                        cnt_q     <= CW'(VW);
                        state_q   <= CONV;
                    end
                end
                CONV: begin
                    scratch_q <= scratch_d;
                    bin_q     <= bin_d;
                    cnt_q     <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        bcd_q       <= scratch_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        // Combined handshake: accept the next operand on the same edge.
                        if (in_valid) begin
                            bin_q     <= {in_cout, in_sum};
                            scratch_q <= '0;
                            cnt_q     <= CW'(VW);
                            state_q   <= CONV;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_to_bcd.sv
// Directed and random checks of sum_to_bcd: reset, latency, corner values,
// backpressure, mid-conversion reset and a decimal reference model.
module tb_sum_to_bcd;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_cout;
    logic [7:0]  in_sum;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] bcd_digits;

    int tests_run;
    int tests_failed;

    sum_to_bcd #(.WIDTH(8), .DIGITS(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cout    (in_cout),
        .in_sum     (in_sum),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .bcd_digits (bcd_digits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after a handshake until out_valid is seen; -1 on timeout.
    task automatic wait_out(output int n);
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (out_valid) begin
                n = i;
                break;
            end
        end
    endtask

    function automatic logic [11:0] bcd_model(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Called with the DUT idle, 1 time unit after a rising edge.
    task automatic do_conv(input logic c, input logic [7:0] s, input logic [11:0] exp);
        int n;
        in_cout  = c;
        in_sum   = s;
        in_valid = 1'b1;
        chk("in_ready_idle", in_ready, 1);
        step();
        in_valid = 1'b0;
        wait_out(n);
        chk("latency", n, 9);
        chk("digits", bcd_digits, exp);
        $display("[TB] conv {%0d,%0d} -> %03h (latency %0d)", c, s, bcd_digits, n);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("out_valid_drop", out_valid, 0);
    endtask

    initial begin
        int          n;
        logic [11:0] held;
        logic        rose;
        int          v;
        int          stall;

        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b1;
        in_valid     = 1'b0;
        in_cout      = 1'b0;
        in_sum       = 8'd0;
        out_ready    = 1'b0;

        // Reset asserted mid-cycle must act without a clock edge.
        #3 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_bcd", bcd_digits, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold_in_ready", in_ready, 1);
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        do_conv(1'b0, 8'd0,   12'h000);
        do_conv(1'b1, 8'd255, 12'h511);
        do_conv(1'b0, 8'd255, 12'h255);
        do_conv(1'b1, 8'd7,   12'h263);
        do_conv(1'b1, 8'd85,  12'h341);
        do_conv(1'b1, 8'd74,  12'h330);

        // Async reset while DONE is presenting a result.
        in_cout = 1'b0; in_sum = 8'd99; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out(n);
        chk("pre_rst_digits", bcd_digits, 12'h099);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_bcd", bcd_digits, 0);
        chk("async_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Backpressure in DONE with a new operand waiting.
        in_cout = 1'b0; in_sum = 8'd200; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out(n);
        chk("bp_first_latency", n, 9);
        chk("bp_first_digits", bcd_digits, 12'h200);
        held = bcd_digits;
        in_cout = 1'b1; in_sum = 8'd123; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", in_ready, 0);
            step();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_digits_stable", bcd_digits, held);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("bp_capture_out_valid", out_valid, 0);
        chk("bp_capture_in_ready", in_ready, 0);
        chk("bp_digits_kept", bcd_digits, held);
        wait_out(n);
        chk("bp_second_latency", n, 9);
        chk("bp_second_digits", bcd_digits, 12'h379);
        $display("[TB] backpressure {1,123} -> %03h (latency %0d)", bcd_digits, n);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset in the middle of converting 511.
        in_cout = 1'b1; in_sum = 8'd255; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        #2 rst_n = 1'b0;
        #1;
        chk("midconv_rst_bcd", bcd_digits, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rose = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (out_valid) rose = 1'b1;
        end
        chk("midconv_no_valid", rose, 0);
        chk("midconv_bcd_zero", bcd_digits, 0);
        do_conv(1'b0, 8'd25, 12'h025);

        // Random operands with random output stalls.
        for (int t = 0; t < 1000; t++) begin
            v = int'($urandom_range(0, 511));
            in_cout  = v[8];
            in_sum   = v[7:0];
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            wait_out(n);
            chk("rnd_latency", n, 9);
            chk("rnd_digits", bcd_digits, bcd_model(v));
            chk("rnd_ones_le9", bcd_digits[3:0] <= 4'd9, 1);
            chk("rnd_tens_le9", bcd_digits[7:4] <= 4'd9, 1);
            chk("rnd_hund_le5", bcd_digits[11:8] <= 4'd5, 1);
            $display("[TB] rnd %0d -> %03h", v, bcd_digits);
            held  = bcd_digits;
            stall = int'($urandom_range(0, 3));
            for (int i = 0; i < stall; i++) begin
                step();
                chk("rnd_stall_valid", out_valid, 1);
                chk("rnd_stall_digits", bcd_digits, held);
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk("rnd_drop", out_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
